// File: rtl/multi_button_processor_pkg.sv
// Shared definitions for the multi-channel button processor: channel state
// encodings, default timing constants and elaboration-time helpers.
package multi_button_processor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_LONG     = 3'd3,
        ST_REL_DB   = 3'd4
    } btn_state_e;

    localparam int DEF_N_CH            = 2;
    localparam int DEF_DEBOUNCE_TIME   = 20;
    localparam int DEF_LONG_PRESS_TIME = 1500;
    localparam int DEF_REPEAT_TIME     = 250;
    localparam int DEF_PULSE_WIDTH     = 10;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/multi_button_processor_channel.sv
// One button channel: input synchroniser, press/release debounce FSM with
// short/long classification and auto-repeat, and a fixed-width pulse stretcher.
module multi_button_processor_channel
    import multi_button_processor_pkg::*;
#(
    parameter int DEBOUNCE_TIME   = DEF_DEBOUNCE_TIME,
    parameter int LONG_PRESS_TIME = DEF_LONG_PRESS_TIME,
    parameter int REPEAT_TIME     = DEF_REPEAT_TIME,
    parameter int PULSE_WIDTH     = DEF_PULSE_WIDTH
) (
    input  logic clk_1khz,
    input  logic rst_ni,
    input  logic button,
    input  logic en,
    output logic count_up,
    output logic count_down,
    output logic pressed
);

    localparam int DB_W   = $clog2(DEBOUNCE_TIME + 1);
    localparam int HOLD_W = $clog2(max_int(LONG_PRESS_TIME, REPEAT_TIME) + 1);
    localparam int PW_W   = $clog2(PULSE_WIDTH + 1);

    localparam bit DB_IS_ONE = (DEBOUNCE_TIME == 1);
    localparam bit REPEAT_ON = (REPEAT_TIME != 0);

    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TIME - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_TIME - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_ON ? REPEAT_TIME - 1 : 0);
    localparam logic [PW_W-1:0]   PW_ZERO   = PW_W'(0);
    localparam logic [PW_W-1:0]   PW_ONE    = PW_W'(1);
    localparam logic [PW_W-1:0]   PW_LAST   = PW_W'(PULSE_WIDTH - 1);

    logic              sync1_r;
    logic              sync2_r;
    btn_state_e        state_r;
    btn_state_e        state_s;
    logic              origin_long_r;
    logic              origin_long_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic [DB_W-1:0]   db_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic              pressed_r;
    logic              pressed_s;
    logic              fire_up_s;
    logic              fire_down_s;
    logic              up_r;
    logic              down_r;
    logic [PW_W-1:0]   pw_cnt_r;

    // Two-flop synchroniser; keeps sampling even while the channel is disabled
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and event decode for the press FSM
    always_comb begin
        state_s       = state_r;
        origin_long_s = origin_long_r;
        db_cnt_s      = db_cnt_r;
        hold_cnt_s    = hold_cnt_r;
        pressed_s     = pressed_r;
        fire_up_s     = 1'b0;
        fire_down_s   = 1'b0;
        if (!en) begin
            state_s       = ST_IDLE;
            origin_long_s = 1'b0;
            db_cnt_s      = DB_ZERO;
            hold_cnt_s    = HOLD_ZERO;
            pressed_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    db_cnt_s   = DB_ZERO;
                    hold_cnt_s = HOLD_ZERO;
                    if (sync2_r) begin
                        if (DB_IS_ONE) begin
                            state_s   = ST_PRESSED;
                            pressed_s = 1'b1;
                        end else begin
                            state_s  = ST_DEBOUNCE;
                            db_cnt_s = DB_ONE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (sync2_r) begin
                        if (db_cnt_r == DB_LAST) begin
                            state_s    = ST_PRESSED;
                            pressed_s  = 1'b1;
                            db_cnt_s   = DB_ZERO;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            db_cnt_s = db_cnt_r + DB_ONE;
                        end
                    end else begin
                        state_s  = ST_IDLE;
                        db_cnt_s = DB_ZERO;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_r) begin
                        if (hold_cnt_r == LONG_LAST) begin
                            state_s     = ST_LONG;
                            fire_down_s = 1'b1;
                            hold_cnt_s  = HOLD_ZERO;
                        end else begin
                            hold_cnt_s = hold_cnt_r + HOLD_ONE;
                        end
                    end else begin
                        origin_long_s = 1'b0;
                        if (DB_IS_ONE) begin
                            state_s    = ST_IDLE;
                            pressed_s  = 1'b0;
                            fire_up_s  = 1'b1;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            state_s  = ST_REL_DB;
                            db_cnt_s = DB_ONE;
                        end
                    end
                end
                ST_LONG: begin
                    if (sync2_r) begin
                        if (!REPEAT_ON) begin
                            hold_cnt_s = hold_cnt_r;
                        end else if (hold_cnt_r == REP_LAST) begin
                            fire_down_s = 1'b1;
                            hold_cnt_s  = HOLD_ZERO;
                        end else begin
                            hold_cnt_s = hold_cnt_r + HOLD_ONE;
                        end
                    end else begin
                        origin_long_s = 1'b1;
                        if (DB_IS_ONE) begin
                            state_s    = ST_IDLE;
                            pressed_s  = 1'b0;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            state_s  = ST_REL_DB;
                            db_cnt_s = DB_ONE;
                        end
                    end
                end
                ST_REL_DB: begin
                    if (!sync2_r) begin
                        if (db_cnt_r == DB_LAST) begin
                            state_s    = ST_IDLE;
                            pressed_s  = 1'b0;
                            fire_up_s  = !origin_long_r;
                            db_cnt_s   = DB_ZERO;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            db_cnt_s = db_cnt_r + DB_ONE;
                        end
                    end else begin
                        // Release glitch: resume where the press left off
                        state_s  = origin_long_r ? ST_LONG : ST_PRESSED;
                        db_cnt_s = DB_ZERO;
                    end
                end
                default: begin
                    state_s       = ST_IDLE;
                    origin_long_s = 1'b0;
                    db_cnt_s      = DB_ZERO;
                    hold_cnt_s    = HOLD_ZERO;
                    pressed_s     = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and debounced level
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            origin_long_r <= 1'b0;
            db_cnt_r      <= DB_ZERO;
            hold_cnt_r    <= HOLD_ZERO;
            pressed_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            origin_long_r <= origin_long_s;
            db_cnt_r      <= db_cnt_s;
            hold_cnt_r    <= hold_cnt_s;
            pressed_r     <= pressed_s;
        end
    end

    // Pulse stretcher; a new event restarts the width and cancels the other output
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            up_r     <= 1'b0;
            down_r   <= 1'b0;
            pw_cnt_r <= PW_ZERO;
        end else if (!en) begin
            up_r     <= 1'b0;
            down_r   <= 1'b0;
            pw_cnt_r <= PW_ZERO;
        end else if (fire_up_s) begin
            up_r     <= 1'b1;
            down_r   <= 1'b0;
            pw_cnt_r <= PW_LAST;
        end else if (fire_down_s) begin
            up_r     <= 1'b0;
            down_r   <= 1'b1;
            pw_cnt_r <= PW_LAST;
        end else if (pw_cnt_r != PW_ZERO) begin
            pw_cnt_r <= pw_cnt_r - PW_ONE;
        end else begin
            up_r   <= 1'b0;
            down_r <= 1'b0;
        end
    end

    assign count_up   = up_r;
    assign count_down = down_r;
    assign pressed    = pressed_r;

endmodule

// File: rtl/multi_button_processor.sv
// N-channel button press processor feeding the scoreboard score counters;
// each channel is an independent instance of multi_button_processor_channel.
module multi_button_processor
    import multi_button_processor_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_TIME   = DEF_DEBOUNCE_TIME,
    parameter int LONG_PRESS_TIME = DEF_LONG_PRESS_TIME,
    parameter int REPEAT_TIME     = DEF_REPEAT_TIME,
    parameter int PULSE_WIDTH     = DEF_PULSE_WIDTH
) (
    input  logic            clk_1khz,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] pushbutton_i,
    input  logic [N_CH-1:0] ch_en_i,
    output logic [N_CH-1:0] count_up,
    output logic [N_CH-1:0] count_down,
    output logic [N_CH-1:0] pressed_o
);

    if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
        $error("multi_button_processor: N_CH must be 1..8");
    end
    if (DEBOUNCE_TIME < 1) begin : g_bad_debounce
        $error("multi_button_processor: DEBOUNCE_TIME must be >= 1");
    end
    if (LONG_PRESS_TIME <= DEBOUNCE_TIME) begin : g_bad_long
        $error("multi_button_processor: LONG_PRESS_TIME must exceed DEBOUNCE_TIME");
    end
    if (PULSE_WIDTH < 1) begin : g_bad_pulse
        $error("multi_button_processor: PULSE_WIDTH must be >= 1");
    end
    if (REPEAT_TIME != 0 && REPEAT_TIME <= PULSE_WIDTH) begin : g_bad_repeat
        $error("multi_button_processor: REPEAT_TIME must exceed PULSE_WIDTH when enabled");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        multi_button_processor_channel #(
            .DEBOUNCE_TIME  (DEBOUNCE_TIME),
            .LONG_PRESS_TIME(LONG_PRESS_TIME),
            .REPEAT_TIME    (REPEAT_TIME),
            .PULSE_WIDTH    (PULSE_WIDTH)
        ) u_channel (
            .clk_1khz  (clk_1khz),
            .rst_ni    (rst_ni),
            .button    (pushbutton_i[i]),
            .en        (ch_en_i[i]),
            .count_up  (count_up[i]),
            .count_down(count_down[i]),
            .pressed   (pressed_o[i])
        );
    end

endmodule

// File: tb/tb_multi_button_processor.sv
// Scoreboard bench: stimulus queues expected output events with their cycle,
// a negedge monitor matches every observed edge and checks pulse widths.
module tb_multi_button_processor;

    localparam int K_UP   = 0;
    localparam int K_DN   = 1;
    localparam int K_PR   = 2;
    localparam int K_REL  = 3;
    localparam int PW     = 3;

    typedef struct {
        int ch;
        int kind;
        int cyc;
    } ev_t;

    logic       clk_1khz;
    logic       rst_ni;
    logic [1:0] pushbutton_i;
    logic [1:0] ch_en_i;
    logic [1:0] count_up;
    logic [1:0] count_down;
    logic [1:0] pressed_o;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    multi_button_processor #(
        .N_CH           (2),
        .DEBOUNCE_TIME  (4),
        .LONG_PRESS_TIME(20),
        .REPEAT_TIME    (8),
        .PULSE_WIDTH    (PW)
    ) dut (
        .clk_1khz    (clk_1khz),
        .rst_ni      (rst_ni),
        .pushbutton_i(pushbutton_i),
        .ch_en_i     (ch_en_i),
        .count_up    (count_up),
        .count_down  (count_down),
        .pressed_o   (pressed_o)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;
    always @(posedge clk_1khz) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_UP:    return "count_up";
            K_DN:    return "count_down";
            K_PR:    return "press";
            default: return "release";
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1khz);
        #1;
    endtask

    task automatic expect_ev(input int c, input int k, input int at);
        ev_t e;
        e.ch = c;
        e.kind = k;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic match(input int c, input int k);
        int idx;
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (idx < 0 && exp_q[j].ch == c && exp_q[j].kind == k && exp_q[j].cyc == cyc) idx = j;
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL event_%s ch%0d actual=seen at cycle %0d required=no such event", kname(k), c, cyc);
        end else begin
            exp_q.delete(idx);
        end
    endtask

    // Monitor: sample away from the active edge and match observed edges
    initial begin
        logic [1:0] prev_up, prev_dn, prev_pr;
        int w_up[2];
        int w_dn[2];
        prev_up = 2'b00; prev_dn = 2'b00; prev_pr = 2'b00;
        w_up[0] = 0; w_up[1] = 0; w_dn[0] = 0; w_dn[1] = 0;
        forever begin
            @(negedge clk_1khz);
            if (!rst_ni) begin
                prev_up = 2'b00; prev_dn = 2'b00; prev_pr = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    w_up[c] = 0;
                    w_dn[c] = 0;
                end
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (count_up[c] && !prev_up[c]) match(c, K_UP);
                    if (count_down[c] && !prev_dn[c]) match(c, K_DN);
                    if (pressed_o[c] && !prev_pr[c]) match(c, K_PR);
                    if (!pressed_o[c] && prev_pr[c]) match(c, K_REL);
                    if (count_up[c]) begin
                        w_up[c]++;
                    end else if (prev_up[c]) begin
                        chk($sformatf("width_up_ch%0d", c), w_up[c], PW);
                        w_up[c] = 0;
                    end
                    if (count_down[c]) begin
                        w_dn[c]++;
                    end else if (prev_dn[c]) begin
                        chk($sformatf("width_down_ch%0d", c), w_dn[c], PW);
                        w_dn[c] = 0;
                    end
                    if (count_up[c] || count_down[c])
                        chk($sformatf("exclusive_ch%0d", c), {31'd0, count_up[c] & count_down[c]}, 32'd0);
                end
                prev_up = count_up;
                prev_dn = count_down;
                prev_pr = pressed_o;
            end
        end
    end

    // Stimulus: directed scenarios, each queuing its expected event cycles
    initial begin
        int k;
        rst_ni = 1'b0;
        pushbutton_i = 2'b00;
        ch_en_i = 2'b11;
        #3;
        chk("reset_count_up", {30'd0, count_up}, 32'd0);
        chk("reset_count_down", {30'd0, count_down}, 32'd0);
        chk("reset_pressed", {30'd0, pressed_o}, 32'd0);
        tick(3);
        rst_ni = 1'b1;
        tick(5);

        // Short press on ch0
        k = cyc;
        expect_ev(0, K_PR, k + 6);
        expect_ev(0, K_UP, k + 16);
        expect_ev(0, K_REL, k + 16);
        pushbutton_i[0] = 1'b1;
        tick(10);
        pushbutton_i[0] = 1'b0;
        tick(20);

        // Bounce on ch0: nothing expected
        pushbutton_i[0] = 1'b1; tick(1);
        pushbutton_i[0] = 1'b0; tick(1);
        pushbutton_i[0] = 1'b1; tick(1);
        pushbutton_i[0] = 1'b0; tick(1);
        pushbutton_i[0] = 1'b1; tick(3);
        pushbutton_i[0] = 1'b0;
        tick(20);

        // Long press with auto-repeat on ch1
        k = cyc;
        expect_ev(1, K_PR, k + 6);
        expect_ev(1, K_DN, k + 26);
        expect_ev(1, K_DN, k + 34);
        expect_ev(1, K_DN, k + 42);
        expect_ev(1, K_DN, k + 50);
        expect_ev(1, K_REL, k + 56);
        pushbutton_i[1] = 1'b1;
        tick(50);
        pushbutton_i[1] = 1'b0;
        tick(20);

        // Release glitch while pressed on ch0
        k = cyc;
        expect_ev(0, K_PR, k + 6);
        expect_ev(0, K_DN, k + 29);
        expect_ev(0, K_REL, k + 38);
        pushbutton_i[0] = 1'b1; tick(8);
        pushbutton_i[0] = 1'b0; tick(2);
        pushbutton_i[0] = 1'b1; tick(22);
        pushbutton_i[0] = 1'b0;
        tick(20);

        // Concurrent short presses
        k = cyc;
        for (int c = 0; c < 2; c++) begin
            expect_ev(c, K_PR, k + 6);
            expect_ev(c, K_UP, k + 16);
            expect_ev(c, K_REL, k + 16);
        end
        pushbutton_i = 2'b11;
        tick(10);
        pushbutton_i = 2'b00;
        tick(6);
        chk("concurrent_count_up", {30'd0, count_up}, 32'd3);
        tick(20);

        // Channel disable mid-press, then re-enable with button held
        k = cyc;
        expect_ev(1, K_PR, k + 6);
        expect_ev(1, K_UP, k + 18);
        expect_ev(1, K_REL, k + 18);
        expect_ev(0, K_PR, k + 6);
        expect_ev(0, K_REL, k + 11);
        expect_ev(0, K_PR, k + 17);
        expect_ev(0, K_UP, k + 26);
        expect_ev(0, K_REL, k + 26);
        pushbutton_i = 2'b11;
        tick(10);
        ch_en_i[0] = 1'b0;
        tick(1);
        chk("disable_pressed", {30'd0, pressed_o}, 32'd2);
        tick(1);
        pushbutton_i[1] = 1'b0;
        tick(1);
        ch_en_i[0] = 1'b1;
        tick(7);
        pushbutton_i[0] = 1'b0;
        tick(20);

        // Asynchronous reset in the middle of a pulse
        k = cyc;
        expect_ev(0, K_PR, k + 6);
        expect_ev(0, K_UP, k + 16);
        expect_ev(0, K_REL, k + 16);
        pushbutton_i[0] = 1'b1;
        tick(10);
        pushbutton_i[0] = 1'b0;
        tick(7);
        chk("pulse_before_reset", {30'd0, count_up}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_count_up", {30'd0, count_up}, 32'd0);
        chk("async_rst_count_down", {30'd0, count_down}, 32'd0);
        chk("async_rst_pressed", {30'd0, pressed_o}, 32'd0);
        tick(3);
        rst_ni = 1'b1;
        tick(30);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            foreach (exp_q[j])
                $display("FAIL missing_%s ch%0d actual=not seen required=cycle %0d",
                         kname(exp_q[j].kind), exp_q[j].ch, exp_q[j].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
